// File: rtl/alu_mult_seq.sv
// alu_mult_seq: shift-add 32x32 unsigned multiplier on the shared EX ALU (zero-operand skip under MULT_ZERO_SKIP_EN)
module alu_mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctl,
  output logic [4:0]       alu_shamt,
  input  logic [WIDTH-1:0] alu_dataout
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] mcand, acc_hi, acc_lo, nxt_hi, nxt_lo;
  logic [CNT_W-1:0] cnt;
  logic carry, zero_skip;
  assign busy      = state == RUN;
  assign done      = state == DONE;
  assign alu_sel   = busy;
  assign alu_a     = alu_sel ? acc_hi : '0;
  assign alu_b     = alu_sel ? mcand : '0;
  assign alu_ctl   = 3'b010;
  assign alu_shamt = '0;
`ifdef MULT_ZERO_SKIP_EN
  assign zero_skip = (src_a == '0) || (src_b == '0);
`else
  assign zero_skip = 1'b0;
`endif
  // one shift-add step; carry rebuilt from operand and sum MSBs since the ALU has no carry-out
  always_comb begin
    carry = (acc_hi[WIDTH-1] & mcand[WIDTH-1]) | ((acc_hi[WIDTH-1] | mcand[WIDTH-1]) & ~alu_dataout[WIDTH-1]);
    {nxt_hi, nxt_lo} = acc_lo[0] ? {carry, alu_dataout, acc_lo[WIDTH-1:1]} : {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
  end
  // sequencer: accept in IDLE, iterate WIDTH times in RUN, publish hi/lo on entry to DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (zero_skip) begin
            hi    <= '0;
            lo    <= '0;
            state <= DONE;
          end else begin
            mcand  <= src_a;
            acc_hi <= '0;
            acc_lo <= src_b;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          cnt    <= cnt + 1'b1;
          if (&cnt) begin
            hi    <= nxt_hi;
            lo    <= nxt_lo;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mult_seq.sv
// tb_alu_mult_seq: table, random and corner-sequence checks of alu_mult_seq against a plain-arithmetic product model
module tb_alu_mult_seq;
  logic clk = 0, rst_n = 0, start = 0;
  logic [31:0] src_a = 0, src_b = 0;
  logic busy, done, alu_sel;
  logic [31:0] hi, lo, alu_a, alu_b, alu_dataout;
  logic [2:0] alu_ctl;
  logic [4:0] alu_shamt;
  int vecs = 0, errs = 0;

  typedef struct {
    logic [31:0] a, b;
    logic [63:0] p;
  } vec_t;
  vec_t tbl[6];

  alu_mult_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .alu_sel(alu_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl), .alu_shamt(alu_shamt),
    .alu_dataout(alu_dataout)
  );

  assign alu_dataout = (alu_ctl == 3'b010) ? alu_a + alu_b : '0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int exp_done(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_ZERO_SKIP_EN
    return (a == 0 || b == 0) ? 1 : 33;
`else
    return 33;
`endif
  endfunction

  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [63:0] p);
    int cyc = 1, bcyc = 0, ed = exp_done(a, b);
    bit bad = 0;
    logic [63:0] prod;
    @(negedge clk);
    src_a = a; src_b = b; start = 1;
    @(posedge clk); #1;
    start = 0; src_a = $urandom; src_b = $urandom;
    while (!done && cyc < 40) begin
      if (busy) bcyc++;
      if (alu_sel !== busy || alu_ctl !== 3'b010 || alu_shamt !== 5'd0 ||
          (!alu_sel && (alu_a !== 0 || alu_b !== 0))) bad = 1;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " done_cycle"}, 64'(cyc), 64'(ed));
    chk({tag, " busy_cycles"}, 64'(bcyc), 64'(ed == 1 ? 0 : 32));
    chk({tag, " alu_if"}, 64'(bad), 64'(0));
    prod = {hi, lo};
    chk({tag, " product"}, prod, p);
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, 64'(done), 64'(0));
    chk({tag, " hold"}, {hi, lo}, p);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " busy"}, 64'(busy), 0);
    chk({tag, " done"}, 64'(done), 0);
    chk({tag, " alu_sel"}, 64'(alu_sel), 0);
    chk({tag, " hilo"}, {hi, lo}, 0);
  endtask

  initial begin
    logic [31:0] a, b;
    int dones, dc;
    logic [63:0] prod;
    tbl[0] = '{32'd3, 32'd5, 64'h0000_0000_0000_000F};
    tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    tbl[2] = '{32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000};
    tbl[3] = '{32'd0, 32'h1234, 64'd0};
    tbl[4] = '{32'h1234, 32'd0, 64'd0};
    tbl[5] = '{32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF};
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1;
    for (int i = 0; i < 6; i++) op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].p);
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = (i % 5 == 4) ? 32'd0 : $urandom;
      op($sformatf("rnd%0d", i), a, b, 64'(a) * 64'(b));
    end
    @(negedge clk);
    src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0; start = 1;
    @(posedge clk); #1;
    start = 0;
    dones = 0; dc = 0; prod = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin dones++; dc = c; prod = {hi, lo}; end
      start = (c == 5);
      if (c == 5) begin src_a = 32'd7; src_b = 32'd11; end
      @(posedge clk); #1;
    end
    chk("repulse dones", 64'(dones), 1);
    chk("repulse done_cycle", 64'(dc), 33);
    chk("repulse product", prod, 64'h1234_5678 * 64'h9ABC_DEF0);
    @(negedge clk);
    src_a = 32'hDEAD_BEEF; src_b = 32'h1000; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (9) @(posedge clk);
    #1;
    chk("midrun busy_before", 64'(busy), 1);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    chk_reset("midrun");
    dones = 0;
    repeat (35) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("midrun no_done", 64'(dones), 0);
    op("7x9", 32'd7, 32'd9, 64'd63);
    @(negedge clk);
    src_a = $urandom | 1; src_b = $urandom | 1; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat ($urandom_range(0, 35)) @(posedge clk);
    #1;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rndreset");
    rst_n = 1;
    op("after_rst", 32'd12, 32'd12, 64'd144);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
